// File: rtl/regfile_loader_if.sv
// Command, load-stream and dump-stream handshakes of regfile_loader.
// The master side is the test/debug transport; the slave side is the loader.
interface regfile_loader_if #(
  parameter int unsigned XLen = 32
);
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_dump_i;
  logic            abort_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLen-1:0] in_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLen-1:0] out_data_o;
  logic            busy_o;
  logic            done_o;

  modport master (
    output cmd_valid_i, cmd_dump_i, abort_i, in_valid_i, in_data_i, out_ready_i,
    input  cmd_ready_o, in_ready_o, out_valid_o, out_data_o, busy_o, done_o
  );

  modport slave (
    input  cmd_valid_i, cmd_dump_i, abort_i, in_valid_i, in_data_i, out_ready_i,
    output cmd_ready_o, in_ready_o, out_valid_o, out_data_o, busy_o, done_o
  );
endinterface

// File: rtl/regfile_loader.sv
// Bulk load/dump initiator for the integer register file: streams words into
// x1..x(NReg-1) through the write port, or out of them through read port 1.
module regfile_loader #(
  parameter int unsigned XLen      = 32,
  parameter int unsigned NReg      = 32,
  localparam int unsigned NRegWidth = $clog2(NReg)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regfile_loader_if.slave      bus,
  output logic [NRegWidth-1:0] rf_a1_o,
  input  logic [XLen-1:0]      rf_rd1_i,
  output logic [NRegWidth-1:0] rf_a3_o,
  output logic                 rf_we3_o,
  output logic [XLen-1:0]      rf_wd3_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DUMP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [NRegWidth-1:0] FirstIdx = NRegWidth'(1);
  localparam logic [NRegWidth-1:0] LastIdx  = NRegWidth'(NReg - 1);

  state_t                state;
  logic [NRegWidth-1:0]  idx;
  logic                  out_valid;
  logic [XLen-1:0]       out_data;
  logic                  done;

  logic in_ready;
  logic write_hs;
  logic capture;

  assign in_ready = (state == LOAD);
  // abort suppresses the write even though in_ready is still up this cycle
  assign write_hs = in_ready && bus.in_valid_i && !bus.abort_i;
  assign capture  = !out_valid || bus.out_ready_i;

  assign rf_a3_o  = in_ready ? idx : '0;
  assign rf_wd3_o = bus.in_data_i;
  assign rf_we3_o = write_hs;
  assign rf_a1_o  = (state == DUMP) ? idx : '0;

  assign bus.cmd_ready_o = (state == IDLE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.done_o      = done;

  // idx is reloaded to 1 on every exit so it never sits at 0 inside a transfer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      idx       <= FirstIdx;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid_i && !bus.abort_i) begin
            idx   <= FirstIdx;
            state <= bus.cmd_dump_i ? DUMP : LOAD;
          end
        end

        LOAD: begin
          if (bus.abort_i) begin
            state <= IDLE;
            idx   <= FirstIdx;
          end else if (write_hs) begin
            if (idx == LastIdx) begin
              state <= IDLE;
              idx   <= FirstIdx;
              done  <= 1'b1;
            end else begin
              idx <= idx + FirstIdx;
            end
          end
        end

        DUMP: begin
          if (bus.abort_i) begin
            state     <= IDLE;
            idx       <= FirstIdx;
            out_valid <= 1'b0;
          end else if (capture) begin
            out_data  <= rf_rd1_i;
            out_valid <= 1'b1;
            if (idx == LastIdx) begin
              state <= DRAIN;
              idx   <= FirstIdx;
            end else begin
              idx <= idx + FirstIdx;
            end
          end
        end

        DRAIN: begin
          if (bus.abort_i) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end else if (bus.out_ready_i) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_no_x0_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_we3_o |-> (rf_a3_o != '0));

  a_out_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid && !bus.out_ready_i && !bus.abort_i) |=> (out_valid && $stable(out_data)));

  a_done_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done |-> (state == IDLE));

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader with a behavioural 32x32 register file
// attached to its read and write ports.
module tb_regfile_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_loader_if #(.XLen(32)) bus ();

  logic [4:0]  rf_a1;
  logic [31:0] rf_rd1;
  logic [4:0]  rf_a3;
  logic        rf_we3;
  logic [31:0] rf_wd3;

  regfile_loader #(.XLen(32), .NReg(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .bus      (bus.slave),
    .rf_a1_o  (rf_a1),
    .rf_rd1_i (rf_rd1),
    .rf_a3_o  (rf_a3),
    .rf_we3_o (rf_we3),
    .rf_wd3_o (rf_wd3)
  );

  // Register file model: x0 reads as zero, but storage at index 0 is kept so
  // an illegal write to x0 remains visible.
  logic [31:0] rf [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_a  = '0;
  logic [31:0] pre_d  = '0;

  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_d;
    else if (rf_we3) rf[rf_a3] <= rf_wd3;
  end
  assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : rf[rf_a1];

  int checks = 0;
  int errors = 0;

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < 32; i++) begin
      pre_we = 1'b1;
      pre_a  = 5'(i);
      pre_d  = (i == 0) ? 32'd0 : base + 32'(i);
      @(negedge clk);
    end
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'd0 || bus.in_ready_o !== 1'b0 ||
        rf_we3 !== 1'b0 || rf_a1 !== 5'd0 || rf_a3 !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b busy=%b done=%b ov=%b od=%h ir=%b we=%b a1=%0d a3=%0d, required 1 0 0 0 0 0 0 0 0",
               bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.out_valid_o, bus.out_data_o,
               bus.in_ready_o, rf_we3, rf_a1, rf_a3);
    end
  endtask

  task automatic test_load();
    preload(32'h0);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL load_start: busy=%b in_ready=%b cmd_ready=%b, required 1 1 0",
               bus.busy_o, bus.in_ready_o, bus.cmd_ready_o);
    end
    for (int i = 1; i < 32; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 32'h1000 + 32'(i);
      #1;
      checks++;
      if (rf_we3 !== 1'b1 || rf_a3 !== 5'(i) || rf_wd3 !== 32'h1000 + 32'(i) || bus.done_o !== 1'b0) begin
        errors++;
        $display("FAIL load_write[%0d]: we=%b a3=%0d wd=%h done=%b, required 1 %0d %h 0",
                 i, rf_we3, rf_a3, rf_wd3, bus.done_o, i, 32'h1000 + 32'(i));
      end
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.done_o !== 1'b1 || bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || rf_we3 !== 1'b0) begin
      errors++;
      $display("FAIL load_done: done=%b cmd_ready=%b busy=%b we=%b, required 1 1 0 0",
               bus.done_o, bus.cmd_ready_o, bus.busy_o, rf_we3);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse: done=%b, required 0", bus.done_o);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rf[i] !== ((i == 0) ? 32'd0 : 32'h1000 + 32'(i))) begin
        errors++;
        $display("FAIL load_content[x%0d]: got %h, required %h",
                 i, rf[i], (i == 0) ? 32'd0 : 32'h1000 + 32'(i));
      end
    end
  endtask

  task automatic test_dump();
    preload(32'hA5A5_0000);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.out_valid_o !== 1'b0 || rf_a1 !== 5'd1) begin
      errors++;
      $display("FAIL dump_start: busy=%b out_valid=%b a1=%0d, required 1 0 1",
               bus.busy_o, bus.out_valid_o, rf_a1);
    end
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'hA5A5_0000 + 32'(i) || bus.done_o !== 1'b0) begin
        errors++;
        $display("FAIL dump_word[%0d]: valid=%b data=%h done=%b, required 1 %h 0",
                 i, bus.out_valid_o, bus.out_data_o, bus.done_o, 32'hA5A5_0000 + 32'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL dump_done: done=%b out_valid=%b cmd_ready=%b, required 1 0 1",
               bus.done_o, bus.out_valid_o, bus.cmd_ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL dump_done_pulse: done=%b, required 0", bus.done_o);
    end
  endtask

  task automatic test_dump_backpressure();
    int          nxt = 1;
    logic        stall = 1'b0;
    logic [31:0] held = '0;
    bit          seen_done = 1'b0;
    preload(32'hC0DE_0000);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b1; bus.out_ready_i = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.done_o === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      if (stall) begin
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== held) begin
          errors++;
          $display("FAIL bp_hold: valid=%b data=%h, required 1 %h", bus.out_valid_o, bus.out_data_o, held);
        end
      end
      bus.out_ready_i = (c % 4 == 0) || (c % 4 == 3);
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
        checks++;
        if (bus.out_data_o !== 32'hC0DE_0000 + 32'(nxt)) begin
          errors++;
          $display("FAIL bp_word[%0d]: got %h, required %h", nxt, bus.out_data_o, 32'hC0DE_0000 + 32'(nxt));
        end
        nxt++;
      end
      stall = (bus.out_valid_o === 1'b1) && !bus.out_ready_i;
      held  = bus.out_data_o;
      @(negedge clk);
    end
    bus.out_ready_i = 1'b0;
    checks++;
    if (!seen_done || nxt != 32) begin
      errors++;
      $display("FAIL bp_complete: done_seen=%0d words=%0d, required 1 31", seen_done, nxt - 1);
    end
    @(negedge clk);
  endtask

  task automatic test_gapped_load();
    int n = -1;
    preload(32'h0);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.done_o === 1'b1) begin
        n = c;
        break;
      end
      bus.in_valid_i = (c % 2 == 0);
      bus.in_data_i  = 32'h2000 + 32'(c / 2 + 1);
      bus.cmd_dump_i = c[0];
      #1;
      checks++;
      if (rf_we3 !== bus.in_valid_i || (bus.in_valid_i && rf_a3 !== 5'(c / 2 + 1))) begin
        errors++;
        $display("FAIL gap_write[c%0d]: we=%b a3=%0d, required %b %0d",
                 c, rf_we3, rf_a3, bus.in_valid_i, c / 2 + 1);
      end
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0; bus.cmd_dump_i = 1'b0;
    checks++;
    if (n != 61) begin
      errors++;
      $display("FAIL gap_length: done after %0d cycles, required 61", n);
    end
    for (int i = 1; i < 32; i++) begin
      checks++;
      if (rf[i] !== 32'h2000 + 32'(i)) begin
        errors++;
        $display("FAIL gap_content[x%0d]: got %h, required %h", i, rf[i], 32'h2000 + 32'(i));
      end
    end
  endtask

  task automatic test_abort_load();
    preload(32'hDEAD_0000);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 32'h3000 + 32'(i);
      @(negedge clk);
    end
    bus.abort_i = 1'b1; bus.in_data_i = 32'h3000 + 32'd11;
    #1;
    checks++;
    if (rf_we3 !== 1'b0) begin
      errors++;
      $display("FAIL abort_we: we=%b, required 0", rf_we3);
    end
    @(negedge clk);
    bus.abort_i = 1'b0; bus.in_valid_i = 1'b0;
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_load_state: cmd_ready=%b busy=%b done=%b, required 1 0 0",
               bus.cmd_ready_o, bus.busy_o, bus.done_o);
    end
    for (int i = 1; i < 32; i++) begin
      checks++;
      if (rf[i] !== ((i <= 10) ? 32'h3000 + 32'(i) : 32'hDEAD_0000 + 32'(i))) begin
        errors++;
        $display("FAIL abort_content[x%0d]: got %h, required %h", i, rf[i],
                 (i <= 10) ? 32'h3000 + 32'(i) : 32'hDEAD_0000 + 32'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_load_done: done=%b, required 0", bus.done_o);
    end
  endtask

  task automatic test_abort_drain();
    preload(32'h7700_0000);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (31) @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h7700_001F || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_entry: valid=%b data=%h busy=%b, required 1 7700001f 1",
               bus.out_valid_o, bus.out_data_o, bus.busy_o);
    end
    bus.out_ready_i = 1'b0; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_drain: valid=%b done=%b cmd_ready=%b, required 0 0 1",
               bus.out_valid_o, bus.done_o, bus.cmd_ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_drain_done: done=%b, required 0", bus.done_o);
    end
  endtask

  task automatic test_abort_idle_priority();
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b0; bus.abort_i = 1'b1;
    bus.in_valid_i = 1'b1; bus.in_data_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (rf_we3 !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore_in: we=%b in_ready=%b, required 0 0", rf_we3, bus.in_ready_o);
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0; bus.abort_i = 1'b0; bus.in_valid_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_priority: busy=%b cmd_ready=%b, required 0 1", bus.busy_o, bus.cmd_ready_o);
    end
  endtask

  task automatic test_reset_mid_dump();
    preload(32'h5500_0000);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b1; bus.out_ready_i = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h5500_0001) begin
      errors++;
      $display("FAIL rst_pre: valid=%b data=%h, required 1 55000001", bus.out_valid_o, bus.out_data_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.out_data_o !== 32'd0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: valid=%b busy=%b done=%b data=%h cmd_ready=%b, required 0 0 0 0 1",
               bus.out_valid_o, bus.busy_o, bus.done_o, bus.out_data_o, bus.cmd_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_dump_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h5500_0001) begin
      errors++;
      $display("FAIL rst_restart: valid=%b data=%h, required 1 55000001", bus.out_valid_o, bus.out_data_o);
    end
    repeat (31) @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_done: done=%b, required 1", bus.done_o);
    end
    bus.out_ready_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_dump_i = 1'b0; bus.abort_i = 1'b0;
    bus.in_valid_i  = 1'b0; bus.in_data_i  = '0;   bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_load();
    test_dump();
    test_dump_backpressure();
    test_gapped_load();
    test_abort_load();
    test_abort_drain();
    test_abort_idle_priority();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
